arith_itofp_pipe: RTL and testbench
===================================

// Module: arith_itofp_pipe
// PURPOSE
//  Pipelined, synthesisable integer-to-floating-point converter with a valid/ready handshake.
//  - Generalises the behavioural u32/u64 converter to any integer width and any IEEE-style
//    format (EXP_WIDTH/MAN_WIDTH).
//  - Signed or unsigned input; round-to-nearest-even; inexact/overflow flags.
//  - Sits in the Arith library as the fabric-mappable itofp/uitofp operator.
// PARAMETERS
//  IN_WIDTH   32  integer operand width (>=2)
//  EXP_WIDTH  8   result exponent width (>=2); bias = 2^(EXP_WIDTH-1)-1
//  MAN_WIDTH  23  result stored-fraction width (>=1); OUT_WIDTH = 1+EXP_WIDTH+MAN_WIDTH
//  SIGNED     0   0: operand unsigned (uitofp); 1: operand two's complement (sitofp)
// PORTS
//  clk          input   1          clock, all state on rising edge
//  rst_n        input   1          asynchronous active-low reset
//  in_valid     input   1          operand present
//  in_ready     output  1          block accepts operand this cycle
//  in_data      input   IN_WIDTH   integer operand
//  out_valid    output  1          result present
//  out_ready    input   1          consumer accepts result this cycle
//  out_data     output  OUT_WIDTH  {sign, biased exponent, fraction}
//  out_inexact  output  1          result != operand exactly (rounded or overflowed)
//  out_overflow output  1          magnitude exceeded format range; out_data = +/-inf
// BEHAVIOUR
//  - Reset:
//    - all stage valid bits, out_valid, out_data, out_inexact, out_overflow = 0.
//    - in_ready = 1 after reset release.
//  - Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
//  - Pipeline: 3 registered stages; latency exactly 3 cycles, throughput 1/cycle.
//    - S1: sign = SIGNED & in_data[MSB]; magnitude = |in_data| as IN_WIDTH-bit unsigned,
//      so the most-negative value gives 2^(IN_WIDTH-1).
//    - S2: leading-one position p (0..IN_WIDTH-1); left-normalise; zero flag if magnitude == 0.
//    - S3: round-nearest-even on normalised mantissa, pack, compute flags.
//  - Stall rule: stage k loads when stage k is empty or its content moves on this cycle.
//    - in_ready = !s1_valid || s1_advance (combinational through the chain, no bubbles).
//    - A stalled stage holds its contents; out_data/flags stay stable while out_valid && !out_ready.
//  - Arithmetic:
//    - exp = bias + p.
//    - Bits below the MAN_WIDTH fraction are guard/round/sticky.
//    - Round up if G && (R || S || LSB).
//    - Mantissa carry-out: fraction = 0, exp += 1.
//    - p < MAN_WIDTH+1: exact, inexact = 0.
//  - Zero operand: out_data = all zeros (+0, never -0); flags = 0.
//  - Overflow: if final exp >= 2^EXP_WIDTH-1 (including via rounding carry):
//    - out_data = {sign, all-ones, zeros}; out_overflow = 1, out_inexact = 1.
//  - No subnormal results are possible (integer magnitude >= 1).
//  - Simultaneous in/out transfer when full: legal, no data loss or duplication.
//  - Reset asserted mid-operation: all in-flight results are discarded; no result is emitted
//    for operands accepted before reset.
//  - in_data is sampled only on an accepting edge; changes while !in_ready are ignored.
// TESTING
//  - Default params, unsigned:
//    - 0 -> 0x00000000, flags 0;
//    - 1 -> 0x3F800000;
//    - 0xFFFFFFFF -> 0x4F800000, inexact = 1.
//  - RNE ties, unsigned 32->f32:
//    - 0x01000001 -> 0x4B800000, inexact;
//    - 0x01000003 -> 0x4B800002, inexact;
//    - 0x00FFFFFF -> 0x4B7FFFFF, exact.
//  - SIGNED=1:
//    - 0xFFFFFFFF (-1) -> 0xBF800000;
//    - 0x80000000 -> 0xCF000000, exact;
//    - 0x00000000 -> 0x00000000.
//  - EXP=5, MAN=10, IN=32, unsigned (f16):
//    - 65504 -> 0x7BFF exact;
//    - 65519 -> 0x7BFF inexact;
//    - 65520 -> 0x7C00, overflow = 1;
//    - 0xFFFFFFFF -> 0x7C00, overflow = 1.
//  - Backpressure:
//    - Stream 1..10 with out_ready low cycles 4-9:
//      - in_ready drops once 3 held;
//      - outputs are 1.0..10.0 in order, none lost or repeated;
//      - out_data is stable while stalled.
//  - Reset mid-stream:
//    - Pulse rst_n low with 3 in flight -> out_valid = 0 asynchronously;
//    - after release, next operand 2 -> 0x40000000 after exactly 3 cycles.

Source files
------------

// File: rtl/arith_itofp_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : arith_itofp_pipe_if
// Brief    : Operand/result handshake bundle for the integer-to-float pipeline
// Revision : 1.0
// ============================================================================
interface arith_itofp_pipe_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_inexact;
    logic                 out_overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/arith_itofp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : arith_itofp_pipe
// Brief    : 3-stage integer-to-IEEE-float converter, RNE, valid/ready stalls
// Revision : 1.0
// ============================================================================
module arith_itofp_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter bit SIGNED    = 1'b0
) (
    input wire                clk,
    input wire                rst_n,
    arith_itofp_pipe_if.slave bus
);
    localparam int OUT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int C_PW      = $clog2(IN_WIDTH);
    localparam int C_XW      = EXP_WIDTH + C_PW + 1;
    localparam int C_EW      = IN_WIDTH + MAN_WIDTH + 1;

    localparam logic [C_XW-1:0]     C_ONE     = 1;
    localparam logic [C_XW-1:0]     C_BIAS    = (C_ONE << (EXP_WIDTH - 1)) - C_ONE;
    localparam logic [C_XW-1:0]     C_EXP_MAX = (C_ONE << EXP_WIDTH) - C_ONE;
    localparam logic [IN_WIDTH-1:0] C_MAG_ONE = 1;
    localparam logic [C_PW-1:0]     C_TOP_POS = C_PW'(IN_WIDTH - 1);

    logic s1_load, s2_load, s3_load;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [IN_WIDTH-1:0]  s1_mag_q,   s1_mag_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sign_q,  s2_sign_d;
    logic                 s2_zero_q,  s2_zero_d;
    logic [C_PW-1:0]      s2_pos_q,   s2_pos_d;
    logic [IN_WIDTH-2:0]  s2_frac_q,  s2_frac_d;

    logic                 out_valid_q,    out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q,     out_data_d;
    logic                 out_inexact_q,  out_inexact_d;
    logic                 out_overflow_q, out_overflow_d;

    logic [C_PW-1:0]      lead_pos;
    logic [C_PW-1:0]      shamt;
    logic [IN_WIDTH-1:0]  norm;
    logic [C_EW-1:0]      ext;
    logic [MAN_WIDTH-1:0] frac;
    logic                 guard_bit, round_bit, sticky_bit, round_up;
    logic [MAN_WIDTH:0]   frac_rnd;
    logic [C_XW-1:0]      exp_full;
    logic                 ovf;

    // Each stage loads when empty or when its content leaves this cycle.
    assign s3_load      = !out_valid_q || bus.out_ready;
    assign s2_load      = !s2_valid_q  || s3_load;
    assign s1_load      = !s1_valid_q  || s2_load;
    assign bus.in_ready = s1_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = SIGNED && bus.in_data[IN_WIDTH-1];
                s1_mag_d  = s1_sign_d ? (~bus.in_data + C_MAG_ONE) : bus.in_data;
            end
        end
    end

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                lead_pos = C_PW'(i);
            end
        end
        shamt = C_TOP_POS - lead_pos;
        norm  = s1_mag_q << shamt;

        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_pos_d   = s2_pos_q;
        s2_frac_d  = s2_frac_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_sign_q;
                // A normalised nonzero magnitude always has its MSB set.
                s2_zero_d = !norm[IN_WIDTH-1];
                s2_pos_d  = lead_pos;
                s2_frac_d = norm[IN_WIDTH-2:0];
            end
        end
    end

    always_comb begin
        ext        = {s2_frac_q, {(MAN_WIDTH + 2){1'b0}}};
        frac       = ext[C_EW-1 -: MAN_WIDTH];
        guard_bit  = ext[IN_WIDTH];
        round_bit  = ext[IN_WIDTH-1];
        sticky_bit = |ext[IN_WIDTH-2:0];
        round_up   = guard_bit && (round_bit || sticky_bit || frac[0]);
        frac_rnd   = {1'b0, frac} + {{MAN_WIDTH{1'b0}}, round_up};
        exp_full   = C_BIAS + {{(C_XW - C_PW){1'b0}}, s2_pos_q}
                            + {{(C_XW - 1){1'b0}}, frac_rnd[MAN_WIDTH]};
        ovf        = exp_full >= C_EXP_MAX;

        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_inexact_d  = out_inexact_q;
        out_overflow_d = out_overflow_q;
        if (s3_load) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                if (s2_zero_q) begin
                    out_data_d     = '0;
                    out_inexact_d  = 1'b0;
                    out_overflow_d = 1'b0;
                end else if (ovf) begin
                    out_data_d     = {s2_sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                    out_inexact_d  = 1'b1;
                    out_overflow_d = 1'b1;
                end else begin
                    out_data_d     = {s2_sign_q, exp_full[EXP_WIDTH-1:0], frac_rnd[MAN_WIDTH-1:0]};
                    out_inexact_d  = guard_bit || round_bit || sticky_bit;
                    out_overflow_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_mag_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_zero_q      <= 1'b0;
            s2_pos_q       <= '0;
            s2_frac_q      <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sign_q      <= s1_sign_d;
            s1_mag_q       <= s1_mag_d;
            s2_valid_q     <= s2_valid_d;
            s2_sign_q      <= s2_sign_d;
            s2_zero_q      <= s2_zero_d;
            s2_pos_q       <= s2_pos_d;
            s2_frac_q      <= s2_frac_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_inexact_q  <= out_inexact_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_inexact  = out_inexact_q;
    assign bus.out_overflow = out_overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_arith_itofp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_itofp_pipe
// Brief    : Directed bench for u32->f32, s32->f32 and u32->f16 conversions
// Revision : 1.0
// ============================================================================
module tb_arith_itofp_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arith_itofp_pipe_if #(.IN_WIDTH(32), .OUT_WIDTH(32)) if_u ();
    arith_itofp_pipe_if #(.IN_WIDTH(32), .OUT_WIDTH(32)) if_s ();
    arith_itofp_pipe_if #(.IN_WIDTH(32), .OUT_WIDTH(16)) if_h ();

    arith_itofp_pipe #(.IN_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23), .SIGNED(1'b0))
        u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));
    arith_itofp_pipe #(.IN_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23), .SIGNED(1'b1))
        u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    arith_itofp_pipe #(.IN_WIDTH(32), .EXP_WIDTH(5), .MAN_WIDTH(10), .SIGNED(1'b0))
        u_dut_h (.clk(clk), .rst_n(rst_n), .bus(if_h));

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if_u.out_valid !== 1'b0 || if_u.out_data !== 32'h0 || if_u.out_inexact !== 1'b0 || if_u.out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_u: got v=%b d=%h i=%b o=%b, want all 0", if_u.out_valid, if_u.out_data, if_u.out_inexact, if_u.out_overflow);
        end
        checks++;
        if (if_s.out_valid !== 1'b0 || if_s.out_data !== 32'h0 || if_s.out_inexact !== 1'b0 || if_s.out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_s: got v=%b d=%h i=%b o=%b, want all 0", if_s.out_valid, if_s.out_data, if_s.out_inexact, if_s.out_overflow);
        end
        checks++;
        if (if_h.out_valid !== 1'b0 || if_h.out_data !== 16'h0 || if_h.out_inexact !== 1'b0 || if_h.out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_h: got v=%b d=%h i=%b o=%b, want all 0", if_h.out_valid, if_h.out_data, if_h.out_inexact, if_h.out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if_u.in_ready !== 1'b1 || if_s.in_ready !== 1'b1 || if_h.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got u=%b s=%b h=%b, want 1 1 1", if_u.in_ready, if_s.in_ready, if_h.in_ready);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] vin  [6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h0100_0001, 32'h0100_0003, 32'h00FF_FFFF};
        logic [31:0] vexp [6] = '{32'h0000_0000, 32'h3F80_0000, 32'h4F80_0000,
                                  32'h4B80_0000, 32'h4B80_0002, 32'h4B7F_FFFF};
        logic        vinx [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            if_u.in_data  = vin[i];
            if_u.in_valid = 1'b1;
            @(posedge clk); #1;
            if_u.in_valid = 1'b0;
            lat = 1;
            while (!if_u.out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (if_u.out_valid !== 1'b1 || lat != 3 || if_u.out_data !== vexp[i] ||
                if_u.out_inexact !== vinx[i] || if_u.out_overflow !== 1'b0) begin
                errors++;
                $display("FAIL uitofp[%0d] in=%h: got v=%b lat=%0d d=%h i=%b o=%b, want v=1 lat=3 d=%h i=%b o=0",
                         i, vin[i], if_u.out_valid, lat, if_u.out_data, if_u.out_inexact, if_u.out_overflow, vexp[i], vinx[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_signed();
        logic [31:0] vin  [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                                  32'h0000_0005, 32'hFFFF_FFFE};
        logic [31:0] vexp [5] = '{32'hBF80_0000, 32'hCF00_0000, 32'h0000_0000,
                                  32'h40A0_0000, 32'hC000_0000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            if_s.in_data  = vin[i];
            if_s.in_valid = 1'b1;
            @(posedge clk); #1;
            if_s.in_valid = 1'b0;
            lat = 1;
            while (!if_s.out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (if_s.out_valid !== 1'b1 || lat != 3 || if_s.out_data !== vexp[i] ||
                if_s.out_inexact !== 1'b0 || if_s.out_overflow !== 1'b0) begin
                errors++;
                $display("FAIL sitofp[%0d] in=%h: got v=%b lat=%0d d=%h i=%b o=%b, want v=1 lat=3 d=%h i=0 o=0",
                         i, vin[i], if_s.out_valid, lat, if_s.out_data, if_s.out_inexact, if_s.out_overflow, vexp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_f16();
        logic [31:0] vin  [6] = '{32'd65504, 32'd65519, 32'd65520, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [15:0] vexp [6] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 16'h7C00, 16'h3C00, 16'h0000};
        logic        vinx [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        vovf [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            if_h.in_data  = vin[i];
            if_h.in_valid = 1'b1;
            @(posedge clk); #1;
            if_h.in_valid = 1'b0;
            lat = 1;
            while (!if_h.out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (if_h.out_valid !== 1'b1 || lat != 3 || if_h.out_data !== vexp[i] ||
                if_h.out_inexact !== vinx[i] || if_h.out_overflow !== vovf[i]) begin
                errors++;
                $display("FAIL f16[%0d] in=%h: got v=%b lat=%0d d=%h i=%b o=%b, want v=1 lat=3 d=%h i=%b o=%b",
                         i, vin[i], if_h.out_valid, lat, if_h.out_data, if_h.out_inexact, if_h.out_overflow,
                         vexp[i], vinx[i], vovf[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] fexp [10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                                   32'h4110_0000, 32'h4120_0000};
        int          sent = 0;
        int          recv = 0;
        int          cyc  = 0;
        bit          stalled_prev = 1'b0;
        bit          drop_seen    = 1'b0;
        bit          extra        = 1'b0;
        logic [31:0] held = '0;
        while (recv < 10 && cyc < 60) begin
            if_u.in_valid  = (sent < 10);
            if_u.in_data   = 32'(sent + 1);
            if_u.out_ready = !(cyc >= 4 && cyc <= 9);
            #1;
            if (stalled_prev && if_u.out_valid) begin
                checks++;
                if (if_u.out_data !== held) begin
                    errors++;
                    $display("FAIL bp_stable cyc=%0d: got d=%h, want held %h", cyc, if_u.out_data, held);
                end
            end
            if (!if_u.in_ready && !drop_seen) begin
                drop_seen = 1'b1;
                checks++;
                if (sent - recv != 3) begin
                    errors++;
                    $display("FAIL bp_ready_drop cyc=%0d: got %0d in flight, want 3", cyc, sent - recv);
                end
            end
            if (if_u.out_valid && if_u.out_ready) begin
                checks++;
                if (if_u.out_data !== fexp[recv]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got d=%h, want %h", recv, if_u.out_data, fexp[recv]);
                end
                recv++;
            end
            if (if_u.in_valid && if_u.in_ready) sent++;
            stalled_prev = if_u.out_valid && !if_u.out_ready;
            held         = if_u.out_data;
            @(posedge clk); #1;
            cyc++;
        end
        if_u.in_valid  = 1'b0;
        if_u.out_ready = 1'b1;
        checks++;
        if (recv != 10 || sent != 10) begin
            errors++;
            $display("FAIL bp_count: got sent=%0d recv=%0d, want 10 10", sent, recv);
        end
        checks++;
        if (!drop_seen) begin
            errors++;
            $display("FAIL bp_ready_drop: got in_ready never low, want low while stalled");
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (if_u.out_valid) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL bp_no_duplicate: got extra out_valid after stream, want none");
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        bit early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_u.in_valid = 1'b1;
            if_u.in_data  = 32'(5 + i);
            @(posedge clk); #1;
        end
        if_u.in_valid  = 1'b0;
        if_u.out_ready = 1'b0;
        checks++;
        if (if_u.out_valid !== 1'b1 || if_u.out_data !== 32'h40A0_0000) begin
            errors++;
            $display("FAIL rst_inflight: got v=%b d=%h, want v=1 d=40a00000", if_u.out_valid, if_u.out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_u.out_valid !== 1'b0 || if_u.out_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: got v=%b d=%h, want v=0 d=0", if_u.out_valid, if_u.out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        if_u.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if_u.in_ready !== 1'b1 || if_u.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got rdy=%b v=%b, want rdy=1 v=0", if_u.in_ready, if_u.out_valid);
        end
        if_u.in_data  = 32'd2;
        if_u.in_valid = 1'b1;
        @(posedge clk); #1;
        if_u.in_valid = 1'b0;
        if_u.in_data  = 32'hDEAD_BEEF;
        lat = 1;
        while (!if_u.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (if_u.out_valid !== 1'b1 || lat != 3 || if_u.out_data !== 32'h4000_0000) begin
            errors++;
            $display("FAIL rst_next: got v=%b lat=%0d d=%h, want v=1 lat=3 d=40000000", if_u.out_valid, lat, if_u.out_data);
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (if_u.out_valid) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL rst_discard: got stale out_valid after reset, want none");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        if_u.in_valid = 1'b0; if_u.in_data = '0; if_u.out_ready = 1'b1;
        if_s.in_valid = 1'b0; if_s.in_data = '0; if_s.out_ready = 1'b1;
        if_h.in_valid = 1'b0; if_h.in_data = '0; if_h.out_ready = 1'b1;
        test_reset();
        test_unsigned();
        test_signed();
        test_f16();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
